mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single 512x16 synchronous-read RAM between the CPU's memory interface (requester A) and a second master such as a program loader or debug port (requester B). Each cycle it selects at most one requester, drives that requester's command onto the RAM, acknowledges it combinationally and returns read data one cycle later. Round-robin priority prevents starvation. An optional lock gives one requester a bounded burst of back-to-back accesses.

## Interface
- ADDR_W, 9, RAM address width
- DATA_W, 16, RAM data width
- MAX_BURST, 4, maximum accesses per locked ownership (2..15)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- a_cmd  in  2  requester A command: 00 NONE, 01 READ, 10 WRITE, 11 treated as NONE
- a_addr  in  ADDR_W  requester A address
- a_wdata  in  DATA_W  requester A write data
- a_lock  in  1  requester A requests burst ownership
- a_ack  out  1  A's command is issued to RAM this cycle
- a_rvalid  out  1  A's read data valid this cycle
- a_rdata  out  DATA_W  A's read data (ram_rdata when a_rvalid, else 0)
- b_cmd, b_addr, b_wdata, b_lock, b_ack, b_rvalid, b_rdata: same as A, for requester B
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_write  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after address is presented
- owner  out  2  00 none, 01 A holds lock, 10 B holds lock

## Operation
- States: IDLE, OWN_A, OWN_B. Registered: state, last-grant pointer `last` (A/B), burst counter `cnt` (4 bits), rd_a, rd_b (pending-read flags).
- Request: x_req = x_cmd is READ or WRITE.
- IDLE, or OWN_x with x_lock=0 (released this cycle, combinationally): only one requester → grant it. Both → grant the one that is not `last`.
- OWN_x with x_lock=1: only x can be granted. If x_cmd is NONE, the cycle is idle and the other requester waits.
- Granted x with x_req: x_ack=1. ram_addr/ram_wdata come from x. ram_write=1 if WRITE. `last` <= x.
- No grant: ram_write=0, ram_addr=0, ram_wdata=0, both acks 0.
- Lock acquisition: granted access with x_lock=1 from IDLE → next state OWN_x, cnt <= 1.
- In OWN_x: each ack increments cnt. When the ack brings cnt to MAX_BURST, next state is IDLE with `last`=x (forced release). The other requester wins the next contention; x may re-acquire if uncontested.
- OWN_x with x_lock=0: state returns to IDLE and cnt <= 0. Any grant that cycle follows IDLE rules, and a grant carrying a new lock re-acquires with cnt <= 1.
- Lock with no access (x_lock=1, x_cmd NONE, no grant) is ignored.
- Read return: rd_x <= x_ack & (x_cmd==READ). x_rvalid = rd_x. x_rdata = rd_x ? ram_rdata : 0.
- owner reflects the registered state.

## Timing
- Reset values: state IDLE, `last`=B (A favored first), cnt 0, rd_a/rd_b 0. While reset=1: acks 0, ram_write 0, rvalids 0, rdata 0, owner 00.
- Ack is combinational, same cycle as the command. Requesters hold cmd/addr/wdata until they see ack.
- Write commits at the rising edge ending the ack cycle. Read data appears on x_rdata exactly one cycle after ack.
- Throughput is one access per cycle. Back-to-back reads by one requester give back-to-back rvalids.
- Reset asserted in a cycle with a pending command: no ack and no RAM write that cycle. A read acked in the cycle before reset still has its rvalid suppressed, because reset clears rd_x.
- Reset mid-burst: ownership dropped and cnt cleared. The next cycle starts in IDLE.
- Command 11 is never acked and never locks.

## Test plan
- Reset, then A WRITE addr 0x005 data 0xBEEF, then A READ 0x005 → a_ack=1 both cycles; a_rvalid=1 with a_rdata=0xBEEF one cycle after the read ack; b_* stay 0.
- A and B both READ every cycle for 4 cycles after reset, no locks → grants alternate A,B,A,B; rvalids alternate one cycle later.
- A lock=1 with 6 consecutive WRITEs while B requests READ, MAX_BURST=4 → A acked 4 times with owner=01; then B acked; then A resumes.
- A acquires lock, drops a_lock after 2 accesses while B is requesting → B acked that same cycle and owner returns to 00 on the next cycle.
- Reset asserted on the cycle after an A READ ack, during OWN_A → a_rvalid stays 0, owner=00, and B is granted normally once reset deasserts.
- a_cmd=11 held while B idle → no ack, ram_write=0, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a shared synchronous-read RAM, with
// optional bounded-burst locking and one-cycle read-data return per requester.
module mem_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        a_cmd,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_lock,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [1:0]        b_cmd,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_lock,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [3:0] MAX_CNT   = 4'(MAX_BURST);

    state_t     state_r, state_s;
    logic       last_b_r, last_b_s;
    logic [3:0] cnt_r, cnt_s;
    logic       rd_a_r, rd_b_r;
    logic       a_req_s, b_req_s, free_s, grant_a_s, grant_b_s;

    // Grant selection and next-state computation.
    always_comb begin
        a_req_s   = (a_cmd == CMD_READ) || (a_cmd == CMD_WRITE);
        b_req_s   = (b_cmd == CMD_READ) || (b_cmd == CMD_WRITE);
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        state_s   = state_r;
        cnt_s     = cnt_r;
        last_b_s  = last_b_r;

        // A lock dropped this cycle releases ownership immediately.
        case (state_r)
            IDLE:    free_s = 1'b1;
            OWN_A:   free_s = ~a_lock;
            OWN_B:   free_s = ~b_lock;
            default: free_s = 1'b1;
        endcase

        if (reset) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else if (free_s) begin
            if (a_req_s && b_req_s) begin
                grant_a_s = last_b_r;
                grant_b_s = ~last_b_r;
            end else begin
                grant_a_s = a_req_s;
                grant_b_s = b_req_s;
            end
        end else if (state_r == OWN_A) begin
            grant_a_s = a_req_s;
        end else begin
            grant_b_s = b_req_s;
        end

        if (free_s) begin
            state_s = IDLE;
            cnt_s   = 4'd0;
            if (grant_a_s && a_lock) begin
                state_s = OWN_A;
                cnt_s   = 4'd1;
            end else if (grant_b_s && b_lock) begin
                state_s = OWN_B;
                cnt_s   = 4'd1;
            end else begin
                state_s = IDLE;
            end
        end else if (grant_a_s || grant_b_s) begin
            // Reaching the burst limit forces release; `last` then favours the other side.
            if (cnt_r + 4'd1 == MAX_CNT) begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end else begin
                cnt_s   = cnt_r + 4'd1;
            end
        end else begin
            cnt_s = cnt_r;
        end

        if (grant_a_s) begin
            last_b_s = 1'b0;
        end else if (grant_b_s) begin
            last_b_s = 1'b1;
        end else begin
            last_b_s = last_b_r;
        end
    end

    // Arbitration state, burst counter and pending-read flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            last_b_r <= 1'b1;
            cnt_r    <= 4'd0;
            rd_a_r   <= 1'b0;
            rd_b_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            last_b_r <= last_b_s;
            cnt_r    <= cnt_s;
            rd_a_r   <= grant_a_s && (a_cmd == CMD_READ);
            rd_b_r   <= grant_b_s && (b_cmd == CMD_READ);
        end
    end

    // RAM command mux and requester-facing outputs.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_write = 1'b0;
        if (grant_a_s) begin
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
            ram_write = (a_cmd == CMD_WRITE);
        end else if (grant_b_s) begin
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
            ram_write = (b_cmd == CMD_WRITE);
        end else begin
            ram_write = 1'b0;
        end
        a_ack    = grant_a_s;
        b_ack    = grant_b_s;
        // Reset masks any read still in flight from the cycle before it.
        a_rvalid = rd_a_r & ~reset;
        b_rvalid = rd_b_r & ~reset;
        a_rdata  = a_rvalid ? ram_rdata : '0;
        b_rdata  = b_rvalid ? ram_rdata : '0;
        owner    = reset ? 2'b00 : state_r;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: a driver queues expected per-cycle
// responses, a negedge monitor pops and compares them against the DUT.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  a_cmd = 2'b00, b_cmd = 2'b00;
    logic [8:0]  a_addr = 9'd0, b_addr = 9'd0;
    logic [15:0] a_wdata = 16'd0, b_wdata = 16'd0;
    logic        a_lock = 1'b0, b_lock = 1'b0;
    logic        a_ack, b_ack, a_rvalid, b_rvalid, ram_write;
    logic [15:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
    logic [8:0]  ram_addr;
    logic [1:0]  owner;

    logic [15:0] mem [512];

    typedef struct {
        string       name;
        logic [63:0] exp;
    } rec_t;

    rec_t q[$];
    int   errors = 0;
    int   checks = 0;

    mem_arbiter #(.ADDR_W(9), .DATA_W(16), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .a_cmd(a_cmd), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write(ram_write),
        .ram_rdata(ram_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model.
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Monitor: compares the observed cycle against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            rec_t r;
            logic [63:0] act;
            r   = q.pop_front();
            act = {a_ack, b_ack, ram_write, ram_addr, ram_wdata, owner,
                   a_rvalid, b_rvalid, a_rdata, b_rdata};
            checks++;
            if (act !== r.exp) begin
                errors++;
                $display("FAIL %s: got ack=%b%b wr=%b addr=%h wd=%h own=%b rv=%b%b ard=%h brd=%h, expected ack=%b%b wr=%b addr=%h wd=%h own=%b rv=%b%b ard=%h brd=%h",
                         r.name, act[63], act[62], act[61], act[60:52], act[51:36], act[35:34],
                         act[33], act[32], act[31:16], act[15:0],
                         r.exp[63], r.exp[62], r.exp[61], r.exp[60:52], r.exp[51:36], r.exp[35:34],
                         r.exp[33], r.exp[32], r.exp[31:16], r.exp[15:0]);
            end
        end
    end

    // Drive one cycle of stimulus and queue the hand-computed response.
    task automatic cyc(input string nm,
                       input logic [1:0] ac, input logic [8:0] aa, input logic [15:0] aw, input logic al,
                       input logic [1:0] bc, input logic [8:0] ba, input logic [15:0] bw, input logic bl,
                       input logic rst, input logic [1:0] eack, input logic [1:0] eown,
                       input logic [1:0] erv, input logic [15:0] ed);
        rec_t r;
        logic        ewr;
        logic [8:0]  eaddr;
        logic [15:0] ewd;
        @(posedge clk);
        #1;
        a_cmd = ac; a_addr = aa; a_wdata = aw; a_lock = al;
        b_cmd = bc; b_addr = ba; b_wdata = bw; b_lock = bl;
        reset = rst;
        ewr   = (eack[1] && ac == 2'b10) || (eack[0] && bc == 2'b10);
        eaddr = eack[1] ? aa : (eack[0] ? ba : 9'd0);
        ewd   = eack[1] ? aw : (eack[0] ? bw : 16'd0);
        r.name = nm;
        r.exp  = {eack[1], eack[0], ewr, eaddr, ewd, eown, erv[1], erv[0],
                  erv[1] ? ed : 16'd0, erv[0] ? ed : 16'd0};
        q.push_back(r);
    endtask

    localparam logic [1:0] N = 2'b00, RD = 2'b01, WR = 2'b10, BAD = 2'b11;

    initial begin
        // name       acmd aaddr  awdata     al    bcmd baddr  bwdata     bl    rst   ack    own    rv     data
        cyc("rst0",   N,  9'h000, 16'h0000, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 16'h0000);
        cyc("rst1",   WR, 9'h005, 16'hBEEF, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 16'h0000);
        cyc("a_wr",   WR, 9'h005, 16'hBEEF, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 16'h0000);
        cyc("a_rd",   RD, 9'h005, 16'h0000, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 16'h0000);
        cyc("a_rv",   N,  9'h000, 16'h0000, 1'b0, WR, 9'h010, 16'h1234, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 16'hBEEF);
        cyc("a_wr2",  WR, 9'h011, 16'h5678, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 16'h0000);
        // Round-robin alternation after a fresh reset.
        cyc("rr_rst", RD, 9'h011, 16'h0000, 1'b0, RD, 9'h010, 16'h0000, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 16'h0000);
        cyc("rr1",    RD, 9'h011, 16'h0000, 1'b0, RD, 9'h010, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 16'h0000);
        cyc("rr2",    RD, 9'h011, 16'h0000, 1'b0, RD, 9'h010, 16'h0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 16'h5678);
        cyc("rr3",    RD, 9'h011, 16'h0000, 1'b0, RD, 9'h010, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 16'h1234);
        cyc("rr4",    RD, 9'h011, 16'h0000, 1'b0, RD, 9'h010, 16'h0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 16'h5678);
        cyc("rr5",    N,  9'h000, 16'h0000, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 16'h1234);
        // Locked burst hits the limit of 4, then B gets in, then A resumes.
        cyc("lk1",    WR, 9'h020, 16'hA000, 1'b1, RD, 9'h005, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 16'h0000);
        cyc("lk2",    WR, 9'h021, 16'hA001, 1'b1, RD, 9'h005, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 16'h0000);
        cyc("lk3",    WR, 9'h022, 16'hA002, 1'b1, RD, 9'h005, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 16'h0000);
        cyc("lk4",    WR, 9'h023, 16'hA003, 1'b1, RD, 9'h005, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 16'h0000);
        cyc("lk_b",   WR, 9'h024, 16'hA004, 1'b1, RD, 9'h005, 16'h0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 16'h0000);
        cyc("lk5",    WR, 9'h024, 16'hA004, 1'b1, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 16'hBEEF);
        cyc("lk6",    WR, 9'h025, 16'hA005, 1'b1, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 16'h0000);
        cyc("lk_rel", N,  9'h000, 16'h0000, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 16'h0000);
        // Early lock release while B waits.
        cyc("er1",    WR, 9'h030, 16'hC001, 1'b1, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 16'h0000);
        cyc("er2",    WR, 9'h031, 16'hC002, 1'b1, RD, 9'h020, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 16'h0000);
        cyc("er_idl", N,  9'h000, 16'h0000, 1'b1, RD, 9'h020, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 16'h0000);
        cyc("er_rel", N,  9'h000, 16'h0000, 1'b0, RD, 9'h020, 16'h0000, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 16'h0000);
        cyc("er_rv",  N,  9'h000, 16'h0000, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 16'hA000);
        // Reset right after a locked A read ack.
        cyc("mr_rd",  RD, 9'h023, 16'h0000, 1'b1, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 16'h0000);
        cyc("mr_rst", RD, 9'h024, 16'h0000, 1'b1, RD, 9'h030, 16'h0000, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 16'h0000);
        cyc("mr_b",   N,  9'h000, 16'h0000, 1'b0, RD, 9'h030, 16'h0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 16'h0000);
        cyc("mr_brv", N,  9'h000, 16'h0000, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 16'hC001);
        cyc("chk_rd", RD, 9'h023, 16'h0000, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 16'h0000);
        cyc("chk_rv", N,  9'h000, 16'h0000, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 16'hA003);
        // Command 11 is never acked and never locks.
        cyc("bad1",   BAD, 9'h040, 16'hFFFF, 1'b1, N, 9'h000, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 16'h0000);
        cyc("bad2",   BAD, 9'h040, 16'hFFFF, 1'b1, N, 9'h000, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 16'h0000);
        cyc("bad_b",  BAD, 9'h040, 16'hFFFF, 1'b1, RD, 9'h031, 16'h0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 16'h0000);
        cyc("bad_rv", N,  9'h000, 16'h0000, 1'b0, N,  9'h000, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 16'hC002);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
